// File: rtl/date_pkg.sv
// Shared types, field codes, range constants and month-length lookup for the date editor.
// Optional feature macro: LEAP_YEAR_EN (29-day February in years divisible by 4).
package date_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EDIT_YEAR  = 3'd1,
    EDIT_MONTH = 3'd2,
    EDIT_DAY   = 3'd3,
    COMMIT     = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_YEAR  = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_DAY   = 2'd3;

  localparam logic [7:0] YEAR_MIN  = 8'h00;
  localparam logic [7:0] YEAR_MAX  = 8'h99;
  localparam logic [7:0] MONTH_MIN = 8'h01;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] DAY_MIN   = 8'h01;

  function automatic logic [1:0] field_for(input state_t s);
    case (s)
      EDIT_YEAR:  field_for = FIELD_YEAR;
      EDIT_MONTH: field_for = FIELD_MONTH;
      EDIT_DAY:   field_for = FIELD_DAY;
      default:    field_for = FIELD_NONE;
    endcase
  endfunction

`ifdef LEAP_YEAR_EN
  // Divisible by 4 in BCD: even tens with units 0/4/8, odd tens with units 2/6.
  function automatic logic is_leap(input logic [7:0] year);
    if (year[4]) begin
      is_leap = (year[3:0] == 4'h2) || (year[3:0] == 4'h6);
    end else begin
      is_leap = (year[3:0] == 4'h0) || (year[3:0] == 4'h4) || (year[3:0] == 4'h8);
    end
  endfunction
`endif

  function automatic logic [7:0] max_day(input logic [7:0] month, input logic [7:0] year);
    case (month)
      8'h04, 8'h06, 8'h09, 8'h11: max_day = 8'h30;
`ifdef LEAP_YEAR_EN
      8'h02: max_day = is_leap(year) ? 8'h29 : 8'h28;
`else
      8'h02: max_day = 8'h28;
`endif
      default: max_day = 8'h31;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_updown.sv
// Two-digit BCD single step up or down with wrap between min and max.
module bcd2_updown (
  input  logic [7:0] value,
  input  logic [7:0] min,
  input  logic [7:0] max,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] result
);

  // Values outside [min,max] wrap as if they sat on the nearest bound.
  always_comb begin
    result = value;
    if (inc && !dec) begin
      if (value >= max) begin
        result = min;
      end else if (value[3:0] >= 4'h9) begin
        result = {value[7:4] + 4'h1, 4'h0};
      end else begin
        result = {value[7:4], value[3:0] + 4'h1};
      end
    end else if (dec && !inc) begin
      if (value <= min) begin
        result = max;
      end else if (value[3:0] == 4'h0) begin
        result = {value[7:4] - 4'h1, 4'h9};
      end else begin
        result = {value[7:4], value[3:0] - 4'h1};
      end
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/date_setter.sv
// Button-driven date editor: capture, step year/month/day in BCD, then strobe load.
// Optional feature macro: LEAP_YEAR_EN (see date_pkg::max_day).
module date_setter
  import date_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       inc_btn,
  input  logic       dec_btn,
  input  logic [3:0] cur_year_y1,
  input  logic [3:0] cur_year_y0,
  input  logic [3:0] cur_month_m1,
  input  logic [3:0] cur_month_m0,
  input  logic [3:0] cur_day_d1,
  input  logic [3:0] cur_day_d0,
  output logic [3:0] year_y1,
  output logic [3:0] year_y0,
  output logic [3:0] month_m1,
  output logic [3:0] month_m0,
  output logic [3:0] day_d1,
  output logic [3:0] day_d0,
  output logic       load,
  output logic       editing,
  output logic [1:0] field
);

  state_t     state;
  state_t     next_state;
  logic [7:0] year;
  logic [7:0] month;
  logic [7:0] day;
  logic [7:0] year_next;
  logic [7:0] month_next;
  logic [7:0] day_next;
  logic [7:0] day_max;
  logic       step_inc;
  logic       step_dec;

  // set_btn takes priority, so a coincident inc/dec is dropped.
  assign step_inc = inc_btn & ~set_btn;
  assign step_dec = dec_btn & ~set_btn;
  assign day_max  = max_day(month, year);

  bcd2_updown u_year (
    .value(year), .min(YEAR_MIN), .max(YEAR_MAX),
    .inc(step_inc), .dec(step_dec), .result(year_next)
  );

  bcd2_updown u_month (
    .value(month), .min(MONTH_MIN), .max(MONTH_MAX),
    .inc(step_inc), .dec(step_dec), .result(month_next)
  );

  bcd2_updown u_day (
    .value(day), .min(DAY_MIN), .max(day_max),
    .inc(step_inc), .dec(step_dec), .result(day_next)
  );

  // Next-state logic of the edit sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (set_btn) next_state = EDIT_YEAR;  else next_state = IDLE;
      EDIT_YEAR:  if (set_btn) next_state = EDIT_MONTH; else next_state = EDIT_YEAR;
      EDIT_MONTH: if (set_btn) next_state = EDIT_DAY;   else next_state = EDIT_MONTH;
      EDIT_DAY:   if (set_btn) next_state = COMMIT;     else next_state = EDIT_DAY;
      COMMIT:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // State, date registers and status outputs, all registered from next_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      year    <= YEAR_MIN;
      month   <= MONTH_MIN;
      day     <= DAY_MIN;
      load    <= 1'b0;
      editing <= 1'b0;
      field   <= FIELD_NONE;
    end else begin
      state   <= next_state;
      load    <= (next_state == COMMIT);
      editing <= (next_state != IDLE);
      field   <= field_for(next_state);
      case (state)
        IDLE: begin
          if (set_btn) begin
            year  <= {cur_year_y1, cur_year_y0};
            month <= {cur_month_m1, cur_month_m0};
            day   <= {cur_day_d1, cur_day_d0};
          end
        end
        EDIT_YEAR: begin
          if (!set_btn) year <= year_next;
        end
        EDIT_MONTH: begin
          // Leaving month edit: pull an over-long day back to the month's length.
          if (set_btn) begin
            if (day > day_max) day <= day_max;
          end else begin
            month <= month_next;
          end
        end
        EDIT_DAY: begin
          if (!set_btn) day <= day_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign year_y1  = year[7:4];
  assign year_y0  = year[3:0];
  assign month_m1 = month[7:4];
  assign month_m0 = month[3:0];
  assign day_d1   = day[7:4];
  assign day_d0   = day[3:0];

endmodule

// File: tb/tb_date_setter.sv
// Self-checking bench for date_setter: directed scenarios plus random button traffic vs. an integer date model.
module tb_date_setter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_btn = 1'b0;
  logic       inc_btn = 1'b0;
  logic       dec_btn = 1'b0;
  logic [3:0] cur_year_y1 = 4'h0, cur_year_y0 = 4'h0;
  logic [3:0] cur_month_m1 = 4'h0, cur_month_m0 = 4'h1;
  logic [3:0] cur_day_d1 = 4'h0, cur_day_d0 = 4'h1;
  logic [3:0] year_y1, year_y0, month_m1, month_m0, day_d1, day_d0;
  logic       load, editing;
  logic [1:0] field;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 year, 2 month, 3 day, 4 commit cycle.
  int m_mode = 0;
  int m_year = 0, m_month = 1, m_day = 1;
  int c_year = 0, c_month = 1, c_day = 1;

  date_setter dut (
    .clk(clk), .rst(rst), .set_btn(set_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .cur_year_y1(cur_year_y1), .cur_year_y0(cur_year_y0),
    .cur_month_m1(cur_month_m1), .cur_month_m0(cur_month_m0),
    .cur_day_d1(cur_day_d1), .cur_day_d0(cur_day_d0),
    .year_y1(year_y1), .year_y0(year_y0), .month_m1(month_m1), .month_m0(month_m0),
    .day_d1(day_d1), .day_d0(day_d0), .load(load), .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    to_bcd = {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int mdays(input int mo, input int yr);
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    if (mo == 2) begin
`ifdef LEAP_YEAR_EN
      if (yr % 4 == 0) return 29;
`endif
      return 28;
    end
    return 31;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cur(input int y, input int mo, input int d);
    c_year = y; c_month = mo; c_day = d;
    {cur_year_y1, cur_year_y0}   = to_bcd(y);
    {cur_month_m1, cur_month_m0} = to_bcd(mo);
    {cur_day_d1, cur_day_d0}     = to_bcd(d);
  endtask

  task automatic model(input bit r, input bit s, input bit i, input bit d);
    bit up, dn;
    int mx;
    up = i && !d;
    dn = d && !i;
    if (r) begin
      m_mode = 0; m_year = 0; m_month = 1; m_day = 1;
    end else begin
      case (m_mode)
        0: if (s) begin m_year = c_year; m_month = c_month; m_day = c_day; m_mode = 1; end
        1: if (s) m_mode = 2;
           else if (up) m_year = (m_year + 1) % 100;
           else if (dn) m_year = (m_year + 99) % 100;
        2: if (s) begin
             m_mode = 3;
             mx = mdays(m_month, m_year);
             if (m_day > mx) m_day = mx;
           end
           else if (up) m_month = (m_month == 12) ? 1 : m_month + 1;
           else if (dn) m_month = (m_month == 1) ? 12 : m_month - 1;
        3: begin
             mx = mdays(m_month, m_year);
             if (s) m_mode = 4;
             else if (up) m_day = (m_day >= mx) ? 1 : m_day + 1;
             else if (dn) m_day = (m_day <= 1) ? mx : m_day - 1;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".year"},  {year_y1, year_y0},   to_bcd(m_year));
    chk({tag, ".month"}, {month_m1, month_m0}, to_bcd(m_month));
    chk({tag, ".day"},   {day_d1, day_d0},     to_bcd(m_day));
    chk({tag, ".load"},  {7'd0, load},    {7'd0, m_mode == 4});
    chk({tag, ".edit"},  {7'd0, editing}, {7'd0, m_mode != 0});
    chk({tag, ".field"}, {6'd0, field},   (m_mode >= 1 && m_mode <= 3) ? 8'(m_mode) : 8'd0);
  endtask

  // One clock: drive buttons, sample one ns after the edge, advance the model and compare.
  task automatic step(input string tag, input bit r, input bit s, input bit i, input bit d);
    rst = r; set_btn = s; inc_btn = i; dec_btn = d;
    @(posedge clk);
    #1;
    model(r, s, i, d);
    check_all(tag);
    rst = 1'b0; set_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    step("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_month_const", {month_m1, month_m0}, 8'h01);

    set_cur(25, 12, 31);
    step("capture", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("capture_day_const", {day_d1, day_d0}, 8'h31);
    chk("capture_field_const", {6'd0, field}, 8'd1);
    step("to_month", 1'b0, 1'b1, 1'b0, 1'b0);
    step("month_wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("month_wrap_const", {month_m1, month_m0}, 8'h01);
    step("month_both", 1'b0, 1'b0, 1'b1, 1'b1);
    step("month_dec_wrap", 1'b0, 1'b0, 1'b0, 1'b1);
    step("to_day", 1'b0, 1'b1, 1'b0, 1'b0);
    step("day_wrap_up", 1'b0, 1'b0, 1'b1, 1'b0);
    step("day_wrap_dn", 1'b0, 1'b0, 1'b0, 1'b1);
    step("set_inc_day", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("commit_day_const", {day_d1, day_d0}, 8'h31);
    step("commit_done", 1'b0, 1'b0, 1'b1, 1'b0);
    step("idle_hold", 1'b0, 1'b0, 1'b0, 1'b1);

    set_cur(99, 5, 10);
    step("cap99", 1'b0, 1'b1, 1'b0, 1'b0);
    step("year_wrap_up", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("year_wrap_const", {year_y1, year_y0}, 8'h00);
    step("year_wrap_dn", 1'b0, 1'b0, 1'b0, 1'b1);
    step("year_9_carry", 1'b0, 1'b0, 1'b0, 1'b1);
    step("year_dec", 1'b0, 1'b0, 1'b0, 1'b1);
    step("to_month2", 1'b0, 1'b1, 1'b0, 1'b0);
    step("mid_reset", 1'b1, 1'b1, 1'b0, 1'b0);
    chk("mid_reset_field", {6'd0, field}, 8'd0);

    for (int k = 0; k < 2; k++) begin
      set_cur(23 + k, 1, 31);
      step("clamp_cap", 1'b0, 1'b1, 1'b0, 1'b0);
      step("clamp_tomonth", 1'b0, 1'b1, 1'b0, 1'b0);
      step("clamp_feb", 1'b0, 1'b0, 1'b1, 1'b0);
      step("clamp_today", 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef LEAP_YEAR_EN
      chk("clamp_const", {day_d1, day_d0}, (k == 1) ? 8'h29 : 8'h28);
`else
      chk("clamp_const", {day_d1, day_d0}, 8'h28);
`endif
      step("clamp_commit", 1'b0, 1'b1, 1'b0, 1'b0);
      step("clamp_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    end

    set_cur(10, 4, 30);
    step("apr_cap", 1'b0, 1'b1, 1'b0, 1'b0);
    step("apr_month", 1'b0, 1'b1, 1'b0, 1'b0);
    step("apr_day", 1'b0, 1'b1, 1'b0, 1'b0);
    step("apr_wrap", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("apr_wrap_const", {day_d1, day_d0}, 8'h01);

    for (int n = 0; n < 600; n++) begin
      set_cur(int'($urandom_range(0, 99)), int'($urandom_range(1, 12)), int'($urandom_range(1, 31)));
      step("rand", $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/date_setter.md
# date_setter

Button-driven editor that writes a new date into the calendar counters, as the counterpart of the counter chain that only advances and displays the date. On entry it captures the running date, lets the user step year, month and day with inc/dec pulses, and validates month length, including leap years when that feature is compiled in. On exit it emits a one-cycle load strobe with the BCD date for the day/month/year counters. It sits between the debounced push-buttons and the load inputs of the calendar counters. Its field output drives the digit-blink logic of the display multiplexer.

## Interface
- No parameters. Field ranges are fixed constants in the package.
- clk  in  1  system clock. One clock domain.
- rst  in  1  synchronous, active-high reset.
- set_btn  in  1  single-cycle pulse, already debounced. Enters edit mode, advances the field, and commits.
- inc_btn  in  1  single-cycle pulse. Increments the current field.
- dec_btn  in  1  single-cycle pulse. Decrements the current field.
- cur_year_y1, cur_year_y0, cur_month_m1, cur_month_m0, cur_day_d1, cur_day_d0  in  4 each  running date in BCD, captured on entry.
- year_y1, year_y0, month_m1, month_m0, day_d1, day_d0  out  4 each  edited date in BCD. Registered.
- load  out  1  one-cycle commit strobe.
- editing  out  1  high in every state except IDLE.
- field  out  2  field being edited: 0 = none, 1 = year, 2 = month, 3 = day.

## Operation
- States: IDLE, EDIT_YEAR, EDIT_MONTH, EDIT_DAY, COMMIT.
- IDLE, on set_btn: capture all cur_* inputs into the output registers, then go to EDIT_YEAR.
- EDIT_YEAR: range 00..99.
  - inc_btn: 99 wraps to 00.
  - dec_btn: 00 wraps to 99.
  - set_btn: go to EDIT_MONTH.
- EDIT_MONTH: range 01..12.
  - inc_btn: 12 wraps to 01.
  - dec_btn: 01 wraps to 12.
  - set_btn: go to EDIT_DAY and, in the same cycle, clamp the day to max_day(month, year) if it exceeds it.
- EDIT_DAY: range 01..max_day.
  - inc_btn: max_day wraps to 01.
  - dec_btn: 01 wraps to max_day.
  - set_btn: go to COMMIT.
- COMMIT: load = 1 for exactly one cycle, then IDLE unconditionally. All buttons are ignored in this state.
- max_day:
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for months 04, 06, 09, 11.
  - 28 or 29 for month 02; see Configuration.
- Arithmetic is pure BCD: digit-wise carry and borrow, and no digit ever holds a value above 9.
- Captured inputs are not validated, except for the day clamp on entry to EDIT_DAY.
- Simultaneous events:
  - set_btn together with inc_btn or dec_btn: set wins and the inc/dec is dropped.
  - inc_btn together with dec_btn: no change.
- Outputs hold their values in IDLE. Counters read them only while load = 1.

## Timing
- Reset values: state IDLE, year 00, month 01, day 01, load 0, editing 0, field 0.
- Reset during editing or COMMIT returns to IDLE with the reset values in the next cycle, and no load is issued.
- set_btn sampled in IDLE: the captured date and editing = 1 are visible on the next cycle.
- inc_btn or dec_btn sampled in cycle N: the new field value is visible in cycle N+1. One step per pulse.
- The day clamp appears in the same cycle as field = 3.
- set_btn sampled in EDIT_DAY in cycle N: load = 1 and field = 0 in cycle N+1, and editing = 0 from cycle N+2.
- editing stays 1 during the COMMIT cycle.
- The date outputs are stable throughout the load cycle.

## Configuration
- LEAP_YEAR_EN defined: February max_day is 29 when the 2-digit year is divisible by 4.
  - Rule in BCD: y1 even and y0 in {0, 4, 8}, or y1 odd and y0 in {2, 6}.
  - Year 00 counts as a leap year.
- LEAP_YEAR_EN undefined: February max_day is always 28. The leap logic is absent from the netlist.

## Structure
- Package date_pkg holds:
  - the state enum;
  - the field codes (FIELD_NONE, FIELD_YEAR, FIELD_MONTH, FIELD_DAY);
  - the range constants (YEAR_MAX = 8'h99, MONTH_MIN = 8'h01, MONTH_MAX = 8'h12, DAY_MIN = 8'h01);
  - the max_day(month, year) function, with its leap branch under LEAP_YEAR_EN.
- Sub-module bcd2_updown: a two-digit BCD up/down step with inputs min, max, inc and dec, and a wrapped 8-bit BCD result.
  - It is combinational and instantiated three times, once per field.
  - The FSM and all output registers live in date_setter.

## Test plan
- Reset, then capture 25/12/31: set_btn with cur = 25/12/31 → year 25, month 12, day 31, editing 1, field 1 on the next cycle.
- Year wrap: in EDIT_YEAR at 99, one inc_btn → 00; then dec_btn → 99.
- Day clamp: captured 23/01/31; set to month, inc once to 02, set → day 28, field 3.
  - With LEAP_YEAR_EN and year 24, the same sequence gives day 29.
- Month and day wrap: at month 12, inc → 01. At day 30 with month 04, inc → 01.
- Commit and simultaneous events: set_btn together with inc_btn in EDIT_DAY → day unchanged, load high for exactly one cycle, then IDLE with editing 0.
- Reset mid-edit: rst in EDIT_MONTH → next cycle IDLE, outputs 00/01/01, load never asserted.
